// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the next-PC sequencer.
package pc_seq_pkg;

   typedef enum logic [1:0] {
      S_RESET,
      S_RUN,
      S_HALT
   } pc_seq_state_t;

   typedef enum logic [2:0] {
      PcSelCur,
      PcSelSeq,
      PcSelJump,
      PcSelBranch,
      PcSelTrap
   } pc_sel_t;

   localparam logic [31:0] PC_STEP    = 32'd4;
   localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

   function automatic logic is_misaligned(input logic [31:0] addr);
      return |addr[1:0];
   endfunction

endpackage

// File: rtl/pc_seq_if.sv
// Core-facing bundle of the next-PC sequencer; slave is the sequencer side.
interface pc_seq_if;

   logic [31:0] pc_current;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        jump;
   logic [31:0] jump_target;
   logic        halt_req;
   logic        resume;
   logic [31:0] pc_next;
   logic        pc_reset;
   logic [31:0] pc_init;
   logic        halted;
   logic        trap;
   logic [31:0] epc;
   logic [31:0] retired;

   modport slave (
      input  pc_current, stall, branch_taken, branch_target, jump, jump_target,
             halt_req, resume,
      output pc_next, pc_reset, pc_init, halted, trap, epc, retired
   );

   modport master (
      output pc_current, stall, branch_taken, branch_target, jump, jump_target,
             halt_req, resume,
      input  pc_next, pc_reset, pc_init, halted, trap, epc, retired
   );

endinterface

// File: rtl/pc_redirect_mux.sv
// Run-state priority decode: picks the pc_next source and flags trap/halt/retire.
module pc_redirect_mux
   import pc_seq_pkg::*;
(
   input  logic    stall_i,
   input  logic    jump_i,
   input  logic    branch_i,
   input  logic    halt_i,
   input  logic    misalign_i,
   output pc_sel_t sel_o,
   output logic    trap_o,
   output logic    halt_o,
   output logic    retire_o
);

   always_comb begin
      sel_o    = PcSelSeq;
      trap_o   = 1'b0;
      halt_o   = 1'b0;
      retire_o = 1'b0;
      if (stall_i) begin
         sel_o = PcSelCur;
      end else if ((jump_i || branch_i) && misalign_i) begin
         sel_o  = PcSelTrap;
         trap_o = 1'b1;
      end else if (halt_i) begin
         sel_o  = PcSelCur;
         halt_o = 1'b1;
      end else if (jump_i) begin
         sel_o    = PcSelJump;
         retire_o = 1'b1;
      end else if (branch_i) begin
         sel_o    = PcSelBranch;
         retire_o = 1'b1;
      end else begin
         retire_o = 1'b1;
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller: reset hold, run/halt FSM, epc and retired counter.
// Optional feature macro: PC_MISALIGN_TRAP_EN (misaligned redirect traps).
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR      = 32'h0000_0000,
   parameter logic [31:0] TRAP_VECTOR       = 32'h0000_0100,
   parameter int unsigned RESET_HOLD_CYCLES = 2
) (
   input logic     clk,
   input logic     reset,
   pc_seq_if.slave bus
);

   localparam int unsigned HoldW = $clog2(RESET_HOLD_CYCLES + 1);

   pc_seq_state_t state_q, state_d;
   logic [HoldW-1:0] hold_q, hold_d;
   logic [31:0] epc_q, epc_d;
   logic [31:0] retired_q, retired_d;

   logic [31:0] jump_tgt, branch_tgt;
   logic        misalign;
   pc_sel_t     sel;
   logic        mux_trap, mux_halt, mux_retire;

`ifdef PC_MISALIGN_TRAP_EN
   assign jump_tgt   = bus.jump_target;
   assign branch_tgt = bus.branch_target;
   assign misalign   = is_misaligned(bus.jump ? bus.jump_target : bus.branch_target);
`else
   // Without the trap, low target bits are simply dropped.
   assign jump_tgt   = bus.jump_target & ALIGN_MASK;
   assign branch_tgt = bus.branch_target & ALIGN_MASK;
   assign misalign   = 1'b0;
`endif

   pc_redirect_mux u_redirect_mux (
      .stall_i   (bus.stall),
      .jump_i    (bus.jump),
      .branch_i  (bus.branch_taken),
      .halt_i    (bus.halt_req),
      .misalign_i(misalign),
      .sel_o     (sel),
      .trap_o    (mux_trap),
      .halt_o    (mux_halt),
      .retire_o  (mux_retire)
   );

   assign bus.pc_init = RESET_VECTOR;
   assign bus.epc     = epc_q;
   assign bus.retired = retired_q;

   always_comb begin
      state_d      = state_q;
      hold_d       = hold_q;
      epc_d        = epc_q;
      retired_d    = retired_q;
      bus.pc_next  = bus.pc_current;
      bus.pc_reset = 1'b0;
      bus.halted   = 1'b0;
      bus.trap     = 1'b0;
      unique case (state_q)
         S_RESET: begin
            bus.pc_reset = 1'b1;
            bus.pc_next  = RESET_VECTOR;
            hold_d       = hold_q + HoldW'(1);
            if (hold_q == HoldW'(RESET_HOLD_CYCLES - 1)) begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            bus.trap = mux_trap;
            unique case (sel)
               PcSelCur:    bus.pc_next = bus.pc_current;
               PcSelSeq:    bus.pc_next = bus.pc_current + PC_STEP;
               PcSelJump:   bus.pc_next = jump_tgt;
               PcSelBranch: bus.pc_next = branch_tgt;
               PcSelTrap:   bus.pc_next = TRAP_VECTOR;
               default:     bus.pc_next = bus.pc_current;
            endcase
`ifdef PC_MISALIGN_TRAP_EN
            if (mux_trap) begin
               epc_d = bus.pc_current;
            end
`endif
            if (mux_retire) begin
               retired_d = retired_q + 32'd1;
            end
            if (mux_halt) begin
               state_d = S_HALT;
            end
         end
         S_HALT: begin
            bus.halted = 1'b1;
            if (bus.resume && !bus.stall) begin
               bus.pc_next = bus.pc_current + PC_STEP;
               retired_d   = retired_q + 32'd1;
               state_d     = S_RUN;
            end
         end
         default: begin
            state_d = S_RESET;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_RESET;
         hold_q    <= '0;
         epc_q     <= '0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         hold_q    <= hold_d;
         epc_q     <= epc_d;
         retired_q <= retired_d;
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; models the external PC register around it.
module tb_pc_sequencer;
   import pc_seq_pkg::*;

   typedef struct {
      logic        stall;
      logic        jump;
      logic [31:0] jt;
      logic        br;
      logic [31:0] bt;
      logic [31:0] pc;
      logic [31:0] exp_next;
      logic        exp_trap;
      logic        exp_ret;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   int   applied = 0;
   int   miscompares = 0;
   logic [31:0] exp_ret;
   logic [31:0] exp_epc;
   vec_t vecs[10];

   always #5 clk = ~clk;

   pc_seq_if bus ();

   pc_sequencer #(
      .RESET_VECTOR     (32'h0000_0000),
      .TRAP_VECTOR      (32'h0000_0100),
      .RESET_HOLD_CYCLES(2)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      applied++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic idle();
      bus.stall         = 1'b0;
      bus.jump          = 1'b0;
      bus.jump_target   = 32'h0;
      bus.branch_taken  = 1'b0;
      bus.branch_target = 32'h0;
      bus.halt_req      = 1'b0;
      bus.resume        = 1'b0;
   endtask

   // One clock: the PC register loads pc_init under pc_reset, else pc_next.
   task automatic tick();
      logic [31:0] nxt;
      logic        rst;
      nxt = bus.pc_next;
      rst = bus.pc_reset;
      @(posedge clk);
      #1;
      bus.pc_current = rst ? bus.pc_init : nxt;
      @(negedge clk);
   endtask

   initial begin
      vecs[0] = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  32'h0000_0100, 32'h0000_0104, 1'b0, 1'b1};
      vecs[1] = '{1'b0, 1'b1, 32'h40, 1'b1, 32'h80, 32'h0000_0010, 32'h0000_0040, 1'b0, 1'b1};
      vecs[2] = '{1'b1, 1'b1, 32'h40, 1'b1, 32'h80, 32'h0000_0010, 32'h0000_0010, 1'b0, 1'b0};
      vecs[3] = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h80, 32'h0000_0020, 32'h0000_0080, 1'b0, 1'b1};
      vecs[4] = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  32'hFFFF_FFFC, 32'h0000_0000, 1'b0, 1'b1};
`ifdef PC_MISALIGN_TRAP_EN
      vecs[5] = '{1'b0, 1'b1, 32'h22, 1'b0, 32'h0,  32'h0000_0030, 32'h0000_0100, 1'b1, 1'b0};
      vecs[6] = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h83, 32'h0000_0040, 32'h0000_0100, 1'b1, 1'b0};
`else
      vecs[5] = '{1'b0, 1'b1, 32'h22, 1'b0, 32'h0,  32'h0000_0030, 32'h0000_0020, 1'b0, 1'b1};
      vecs[6] = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h83, 32'h0000_0040, 32'h0000_0080, 1'b0, 1'b1};
`endif
      vecs[7] = '{1'b0, 1'b1, 32'h60, 1'b1, 32'h81, 32'h0000_0044, 32'h0000_0060, 1'b0, 1'b1};
      vecs[8] = '{1'b1, 1'b1, 32'h22, 1'b0, 32'h0,  32'h0000_0048, 32'h0000_0048, 1'b0, 1'b0};
      vecs[9] = '{1'b0, 1'b1, 32'hFFFF_FFF0, 1'b0, 32'h0, 32'h0000_0008, 32'hFFFF_FFF0, 1'b0,
                  1'b1};

      idle();
      reset = 1'b1;
      bus.pc_current = 32'hDEAD_BEEF;
      @(negedge clk);
      tick();
      tick();
      tick();
      #1;
      chk("reset pc_reset", {31'h0, bus.pc_reset}, 32'h1);
      chk("reset pc_next", bus.pc_next, 32'h0);
      chk("reset halted", {31'h0, bus.halted}, 32'h0);
      chk("reset trap", {31'h0, bus.trap}, 32'h0);
      chk("reset epc", bus.epc, 32'h0);
      chk("reset retired", bus.retired, 32'h0);
      chk("reset pc_init", bus.pc_init, 32'h0);

      // Release: pc_reset stays high for two more cycles.
      reset = 1'b0;
      #1;
      chk("hold cycle 1 pc_reset", {31'h0, bus.pc_reset}, 32'h1);
      tick();
      #1;
      chk("hold cycle 2 pc_reset", {31'h0, bus.pc_reset}, 32'h1);
      tick();
      #1;
      chk("run pc_reset", {31'h0, bus.pc_reset}, 32'h0);
      chk("fetch 0", bus.pc_current, 32'h0);
      chk("first pc_next", bus.pc_next, 32'h4);
      tick();
      chk("fetch 1", bus.pc_current, 32'h4);
      tick();
      chk("fetch 2", bus.pc_current, 32'h8);
      chk("retired after fetch 2", bus.retired, 32'h2);
      exp_ret = 32'h2;
      exp_epc = 32'h0;

      for (int i = 0; i < 10; i++) begin
         idle();
         bus.stall         = vecs[i].stall;
         bus.jump          = vecs[i].jump;
         bus.jump_target   = vecs[i].jt;
         bus.branch_taken  = vecs[i].br;
         bus.branch_target = vecs[i].bt;
         bus.pc_current    = vecs[i].pc;
         #1;
         chk($sformatf("vec%0d pc_next", i), bus.pc_next, vecs[i].exp_next);
         chk($sformatf("vec%0d trap", i), {31'h0, bus.trap}, {31'h0, vecs[i].exp_trap});
         tick();
         if (vecs[i].exp_ret) exp_ret = exp_ret + 32'd1;
         if (vecs[i].exp_trap) exp_epc = vecs[i].pc;
         chk($sformatf("vec%0d retired", i), bus.retired, exp_ret);
         chk($sformatf("vec%0d epc", i), bus.epc, exp_epc);
         chk($sformatf("vec%0d halted", i), {31'h0, bus.halted}, 32'h0);
      end

      // Halt at 0x50, hold five cycles against noise, one stalled resume, then resume.
      idle();
      bus.pc_current = 32'h50;
      bus.halt_req   = 1'b1;
      #1;
      chk("halt entry pc_next", bus.pc_next, 32'h50);
      tick();
      for (int i = 0; i < 5; i++) begin
         idle();
         bus.jump         = 1'b1;
         bus.jump_target  = 32'h200;
         bus.branch_taken = 1'b1;
         bus.halt_req     = 1'b1;
         bus.stall        = (i == 4);
         bus.resume       = (i == 4);
         #1;
         chk($sformatf("halt%0d halted", i), {31'h0, bus.halted}, 32'h1);
         chk($sformatf("halt%0d pc_next", i), bus.pc_next, 32'h50);
         tick();
         chk($sformatf("halt%0d pc", i), bus.pc_current, 32'h50);
      end
      chk("halt retired", bus.retired, exp_ret);
      idle();
      bus.resume = 1'b1;
      #1;
      chk("resume pc_next", bus.pc_next, 32'h54);
      tick();
      exp_ret = exp_ret + 32'd1;
      chk("resume pc", bus.pc_current, 32'h54);
      chk("resume halted", {31'h0, bus.halted}, 32'h0);
      chk("resume retired", bus.retired, exp_ret);

      // Retired counter wrap.
      idle();
      dut.retired_q = 32'hFFFF_FFFF;
      #1;
      tick();
      chk("retired wrap", bus.retired, 32'h0);

      // Reset while halted overrides a concurrent resume.
      idle();
      bus.pc_current = 32'h70;
      bus.halt_req   = 1'b1;
      #1;
      tick();
      chk("pre-reset halted", {31'h0, bus.halted}, 32'h1);
      idle();
      bus.resume = 1'b1;
      bus.jump   = 1'b1;
      reset      = 1'b1;
      #1;
      tick();
      #1;
      chk("halt reset halted", {31'h0, bus.halted}, 32'h0);
      chk("halt reset pc_reset", {31'h0, bus.pc_reset}, 32'h1);
      chk("halt reset pc_next", bus.pc_next, 32'h0);
      chk("halt reset epc", bus.epc, 32'h0);
      chk("halt reset retired", bus.retired, 32'h0);
      tick();
      chk("halt reset pc reload", bus.pc_current, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end

endmodule
